wght_upd_ctrl: RTL and testbench

Sequencing controller for one weight-accumulator datapath in the backprop engine. It clears the accumulator, gates its enable over a mini-batch of `i_batch` gradient samples, then applies the update `w_new = w - acc`. It presents the registered new weight with a one-cycle valid pulse. It sits between the layer scheduler (start/done) and one accumulator plus weight-register pair.

---
 rtl/wght_upd_ctrl.sv | 120 ++++++++++++
 tb/tb_wght_upd_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wght_upd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : wght_upd_ctrl
// Brief    : Mini-batch weight-update sequencer: clear acc, gate acc over
//            i_batch samples, then register w_new = w - acc with a valid pulse.
//            Option macro WGHT_SAT_EN: saturating (vs. wrapping) subtraction.
// Revision : 1.0  initial release
// ============================================================================
module wght_upd_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_batch,
    input  logic             i_abort,
    input  logic             i_valid,
    output logic             o_ready,
    output logic             o_acc_en,
    output logic             o_acc_clr,
    input  logic [WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0] i_w,
    output logic [WIDTH-1:0] o_w,
    output logic             o_w_valid,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_ACC    = 3'd2,
        S_UPDATE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_batch;
    logic [CNT_W-1:0] r_cnt;
    logic             r_acc_clr;
    logic             r_w_valid;
    logic [WIDTH-1:0] r_w;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_upd;

    assign w_cnt_nxt = r_cnt + 1'b1;

`ifdef WGHT_SAT_EN
    logic [WIDTH:0] w_diff;

    // One guard bit: overflow shows up as disagreement between the top two bits.
    always_comb begin
        w_diff = {i_w[WIDTH-1], i_w} - {i_acc[WIDTH-1], i_acc};
        w_upd  = w_diff[WIDTH-1:0];
        if (w_diff[WIDTH] != w_diff[WIDTH-1]) begin
            w_upd = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_upd = i_w - i_acc;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_batch   <= '0;
            r_cnt     <= '0;
            r_acc_clr <= 1'b0;
            r_w_valid <= 1'b0;
            r_w       <= '0;
        end else if (i_abort) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_acc_clr <= 1'b0;
            r_w_valid <= 1'b0;
        end else begin
            r_acc_clr <= 1'b0;
            r_w_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start && (i_batch != '0)) begin
                        r_batch   <= i_batch;
                        r_cnt     <= '0;
                        r_acc_clr <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end
                S_CLEAR: r_state <= S_ACC;
                S_ACC: begin
                    if (i_valid) begin
                        r_cnt <= w_cnt_nxt;
                        if (w_cnt_nxt == r_batch) begin
                            r_state <= S_UPDATE;
                        end
                    end
                end
                S_UPDATE: begin
                    r_w       <= w_upd;
                    r_w_valid <= 1'b1;
                    r_state   <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Abort must silence every strobe in the very cycle it is seen.
    assign o_ready   = (r_state == S_ACC) && !i_abort;
    assign o_acc_en  = o_ready && i_valid;
    assign o_acc_clr = r_acc_clr && !i_abort;
    assign o_w_valid = r_w_valid && !i_abort;
    assign o_busy    = (r_state != S_IDLE);
    assign o_cnt     = r_cnt;
    assign o_w       = r_w;

endmodule
`default_nettype wire

// File: tb/tb_wght_upd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_wght_upd_ctrl
// Brief    : Self-checking bench for wght_upd_ctrl with a transaction-level
//            reference for the weight update (honours WGHT_SAT_EN).
// Revision : 1.0  initial release
// ============================================================================
module tb_wght_upd_ctrl;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_batch;
    logic             i_abort;
    logic             i_valid;
    logic             o_ready;
    logic             o_acc_en;
    logic             o_acc_clr;
    logic [WIDTH-1:0] i_acc;
    logic [WIDTH-1:0] i_w;
    logic [WIDTH-1:0] o_w;
    logic             o_w_valid;
    logic             o_busy;
    logic [CNT_W-1:0] o_cnt;

    int               n_chk  = 0;
    int               n_pass = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] exp_w  = '0;

    wght_upd_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_batch   (i_batch),
        .i_abort   (i_abort),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_acc_en  (o_acc_en),
        .o_acc_clr (o_acc_clr),
        .i_acc     (i_acc),
        .i_w       (i_w),
        .o_w       (o_w),
        .o_w_valid (o_w_valid),
        .o_busy    (o_busy),
        .o_cnt     (o_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference: exact integer difference, then clamp or truncate to WIDTH.
    function automatic logic [WIDTH-1:0] model_upd(input logic [WIDTH-1:0] w,
                                                   input logic [WIDTH-1:0] acc);
        longint d;
        d = longint'($signed(w)) - longint'($signed(acc));
`ifdef WGHT_SAT_EN
        if (d > (longint'(1) <<< (WIDTH-1)) - 1) d = (longint'(1) <<< (WIDTH-1)) - 1;
        if (d < -(longint'(1) <<< (WIDTH-1)))    d = -(longint'(1) <<< (WIDTH-1));
`endif
        return d[WIDTH-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},  o_ready,   0);
        check({tag, "_acc_en"}, o_acc_en,  0);
        check({tag, "_clr"},    o_acc_clr, 0);
        check({tag, "_w"},      o_w,       0);
        check({tag, "_wvalid"}, o_w_valid, 0);
        check({tag, "_busy"},   o_busy,    0);
        check({tag, "_cnt"},    o_cnt,     0);
    endtask

    // One full batch. pat/patlen give a directed valid pattern (ones after it);
    // patlen == 0 means random valid gaps. Start must be issued from IDLE.
    task automatic run_batch(input int n, input logic [31:0] pat, input int patlen,
                             input logic [WIDTH-1:0] w, input logic [WIDTH-1:0] acc);
        int cnt = 0;
        int i   = 0;
        i_start = 1'b1;
        i_batch = n[CNT_W-1:0];
        tick();
        i_start = 1'b0;
        i_valid = 1'b1;
        #1;
        check("clear_pulse",  o_acc_clr, 1);
        check("clear_acc_en", o_acc_en,  0);
        check("clear_busy",   o_busy,    1);
        check("clear_cnt",    o_cnt,     0);
        tick();
        while (cnt < n && i < 1000) begin
            if (patlen == 0)     i_valid = 1'($urandom_range(0, 1));
            else if (i < patlen) i_valid = pat[i];
            else                 i_valid = 1'b1;
            i_start = 1'($urandom_range(0, 1));
            i_batch = CNT_W'($urandom);
            #1;
            check("acc_ready",  o_ready,   1);
            check("acc_en",     o_acc_en,  i_valid);
            check("acc_cnt",    o_cnt,     cnt);
            check("acc_clr",    o_acc_clr, 0);
            if (i_valid) cnt++;
            i++;
            tick();
        end
        check("acc_done_in_budget", cnt, n);
        i_start = 1'b0;
        i_valid = 1'b1;
        i_w     = w;
        i_acc   = acc;
        exp_w   = model_upd(w, acc);
        #1;
        check("upd_ready",  o_ready,   0);
        check("upd_acc_en", o_acc_en,  0);
        check("upd_busy",   o_busy,    1);
        check("upd_wvalid", o_w_valid, 0);
        check("upd_cnt",    o_cnt,     n);
        tick();
        i_start = 1'b1;
        i_batch = 8'd1;
        i_w     = $urandom;
        i_acc   = $urandom;
        #1;
        check("done_wvalid", o_w_valid, 1);
        check("done_w",      o_w,       exp_w);
        check("done_busy",   o_busy,    1);
        tick();
        i_start = 1'b0;
        i_valid = 1'b0;
        #1;
        check("idle_busy",   o_busy,    0);
        check("idle_clr",    o_acc_clr, 0);
        check("idle_wvalid", o_w_valid, 0);
        check("idle_w_hold", o_w,       exp_w);
    endtask

    initial begin
        rst     = 1'b1;
        i_start = 1'b0;
        i_batch = '0;
        i_abort = 1'b0;
        i_valid = 1'b0;
        i_acc   = '0;
        i_w     = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        run_batch(4, 32'hFFFF_FFFF, 4, 32'h0100_0000, 32'h0040_0000);
        check("basic_w", o_w, 32'h00C0_0000);

        run_batch(3, 32'b101001, 6, $urandom, $urandom);

        // Zero-size start is ignored.
        i_start = 1'b1;
        i_batch = '0;
        tick();
        i_start = 1'b0;
        #1;
        check("zero_busy", o_busy,    0);
        check("zero_clr",  o_acc_clr, 0);
        tick();
        check("zero_busy2", o_busy, 0);

        // Abort in ACC at count 2 of a batch of 5.
        i_start = 1'b1;
        i_batch = 8'd5;
        tick();
        i_start = 1'b0;
        i_valid = 1'b1;
        tick();
        tick();
        tick();
        i_abort = 1'b1;
        #1;
        check("abort_cnt_before", o_cnt,    2);
        check("abort_acc_en",     o_acc_en, 0);
        check("abort_ready",      o_ready,  0);
        tick();
        i_abort = 1'b0;
        i_valid = 1'b0;
        #1;
        check("abort_busy",  o_busy, 0);
        check("abort_cnt",   o_cnt,  0);
        check("abort_w",     o_w,    exp_w);
        tick();
        check("abort_wvalid", o_w_valid, 0);

        run_batch(1, 32'hFFFF_FFFF, 1, 32'h8000_0001, 32'h0000_0010);
`ifdef WGHT_SAT_EN
        check("sat_under", o_w, 32'h8000_0000);
`else
        check("wrap_under", o_w, 32'h7FFF_FFF1);
`endif
        run_batch(2, 32'hFFFF_FFFF, 2, 32'h7FFF_FFF0, 32'hFFFF_FF00);
`ifdef WGHT_SAT_EN
        check("sat_over", o_w, 32'h7FFF_FFFF);
`else
        check("wrap_over", o_w, 32'h8000_00F0);
`endif

        for (int k = 0; k < 4; k++) begin
            run_batch($urandom_range(1, 8), 32'h0, 0, $urandom, $urandom);
        end

        // Asynchronous reset while in UPDATE.
        i_start = 1'b1;
        i_batch = 8'd1;
        tick();
        i_start = 1'b0;
        i_valid = 1'b1;
        tick();
        tick();
        check("pre_rst_busy", o_busy, 1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        i_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_batch(2, 32'h0, 0, $urandom, $urandom);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
